// File: rtl/state_seq_monitor.sv
// state_seq_monitor
//   Watches the 2-bit state code of an upstream Moore FSM that should step
//   00 -> 01 -> 10 -> 11 -> 00. It locks onto the sequence, counts full
//   wraps, flags out-of-order steps, and resyncs on the next 00 after an error.
//
//   Optional feature: define STATE_MON_DWELL_EN to add a dwell counter and the
//   dwell_timeout output, which flags a code held for DWELL_MAX or more
//   consecutive valid samples while tracking.
//
// Ports
//   clk            clock, all state on rising edge
//   reset          asynchronous active-low reset
//   in_state[1:0]  observed state code
//   in_valid       in_state is sampled only when high
//   clr            synchronous clear; takes priority over a valid sample
//   locked         high while tracking a legal sequence
//   err            sticky violation flag
//   err_count[7:0] violation count, saturates at 255
//   cycle_count    completed 11->00 wraps, modulo 2^CNT_W
//   last_state     last accepted code
//   dwell_timeout  (STATE_MON_DWELL_EN only) hold count >= DWELL_MAX
module state_seq_monitor #(
    parameter int CNT_W     = 16,
    parameter int DWELL_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       in_state,
    input  logic             in_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       last_state
`ifdef STATE_MON_DWELL_EN
    ,
    output logic             dwell_timeout
`endif
);

    if (DWELL_MAX < 1 || DWELL_MAX > 255) begin : g_bad_dwell
        $error("DWELL_MAX must be in 1..255");
    end

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        ERROR   = 2'd2
    } state_e;

    state_e           state_q;
    logic             locked_q;
    logic             err_q;
    logic [7:0]       err_cnt_q;
    logic [CNT_W-1:0] cycle_q;
    logic [1:0]       last_q;

    logic [1:0] adv_code;
    logic       is_hold;
    logic       is_adv;
    logic [7:0] err_cnt_inc;

    assign adv_code    = last_q + 2'd1;
    assign is_hold     = (in_state == last_q);
    assign is_adv      = (in_state == adv_code);
    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

`ifdef STATE_MON_DWELL_EN
    localparam logic [7:0] DW_MAX = 8'(DWELL_MAX);
    logic [7:0] dwell_q;
    logic       dwell_to_q;
    logic [7:0] dwell_inc;
    assign dwell_inc     = (dwell_q == 8'hFF) ? 8'hFF : dwell_q + 8'd1;
    assign dwell_timeout = dwell_to_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ACQUIRE;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
            cycle_q    <= '0;
            last_q     <= 2'b00;
`ifdef STATE_MON_DWELL_EN
            dwell_q    <= 8'd0;
            dwell_to_q <= 1'b0;
`endif
        end else if (clr) begin
            // last_q deliberately kept; the pending sample is dropped
            state_q    <= ACQUIRE;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
            cycle_q    <= '0;
`ifdef STATE_MON_DWELL_EN
            dwell_q    <= 8'd0;
            dwell_to_q <= 1'b0;
`endif
        end else if (in_valid) begin
            case (state_q)
                ACQUIRE: begin
                    last_q   <= in_state;
                    state_q  <= TRACK;
                    locked_q <= 1'b1;
                end
                TRACK: begin
                    if (is_hold) begin
`ifdef STATE_MON_DWELL_EN
                        dwell_q    <= dwell_inc;
                        dwell_to_q <= (dwell_inc >= DW_MAX);
`endif
                    end else if (is_adv) begin
                        last_q <= in_state;
                        if (last_q == 2'b11) cycle_q <= cycle_q + CNT_W'(1);
`ifdef STATE_MON_DWELL_EN
                        dwell_q    <= 8'd0;
                        dwell_to_q <= 1'b0;
`endif
                    end else begin
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_inc;
                        last_q    <= in_state;
                        state_q   <= ERROR;
                        locked_q  <= 1'b0;
`ifdef STATE_MON_DWELL_EN
                        dwell_q    <= 8'd0;
                        dwell_to_q <= 1'b0;
`endif
                    end
                end
                ERROR: begin
                    // Only a 00 resyncs; no further error counting while here
                    last_q <= in_state;
                    if (in_state == 2'b00) begin
                        state_q  <= TRACK;
                        locked_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ACQUIRE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked      = locked_q;
    assign err         = err_q;
    assign err_count   = err_cnt_q;
    assign cycle_count = cycle_q;
    assign last_state  = last_q;

endmodule

// File: tb/tb_state_seq_monitor.sv
module tb_state_seq_monitor;

    localparam int CW = 4;   // narrow so wraps of cycle_count are reachable
    localparam int DM = 3;

    logic          clk;
    logic          reset;
    logic [1:0]    in_state;
    logic          in_valid;
    logic          clr;
    logic          locked;
    logic          err;
    logic [7:0]    err_count;
    logic [CW-1:0] cycle_count;
    logic [1:0]    last_state;
`ifdef STATE_MON_DWELL_EN
    logic          dwell_timeout;
`endif

    state_seq_monitor #(.CNT_W(CW), .DWELL_MAX(DM)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_state   (in_state),
        .in_valid   (in_valid),
        .clr        (clr),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count),
        .cycle_count(cycle_count),
        .last_state (last_state)
`ifdef STATE_MON_DWELL_EN
        ,
        .dwell_timeout(dwell_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int lk, int er, int ec, int cy, int ls);
        chk({tag, ".locked"},      int'(locked),      lk);
        chk({tag, ".err"},         int'(err),         er);
        chk({tag, ".err_count"},   int'(err_count),   ec);
        chk({tag, ".cycle_count"}, int'(cycle_count), cy);
        chk({tag, ".last_state"},  int'(last_state),  ls);
    endtask

    // Drive one sample and return 1 time unit after the capturing edge.
    task automatic drive(bit v, bit c, bit [1:0] s);
        in_valid = v;
        clr      = c;
        in_state = s;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        clr      = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Reference model: phase 0 = acquiring, 1 = tracking, 2 = in error
    int m_phase, m_last, m_ec, m_cyc, m_dwell;
    bit m_err;

    task automatic model_reset();
        m_phase = 0; m_last = 0; m_ec = 0; m_cyc = 0; m_dwell = 0; m_err = 0;
    endtask

    task automatic model_step(bit v, bit c, bit [1:0] s);
        int d;
        if (c) begin
            m_phase = 0; m_err = 0; m_ec = 0; m_cyc = 0; m_dwell = 0;
        end else if (v) begin
            d = (int'(s) - m_last + 4) % 4;   // 0 = hold, 1 = step forward
            if (m_phase == 0) begin
                m_last = s; m_phase = 1;
            end else if (m_phase == 1) begin
                if (d == 0) begin
                    m_dwell = (m_dwell < 255) ? m_dwell + 1 : 255;
                end else if (d == 1) begin
                    if (m_last == 3) m_cyc = (m_cyc + 1) % (1 << CW);
                    m_last = s; m_dwell = 0;
                end else begin
                    m_err = 1; m_ec = (m_ec < 255) ? m_ec + 1 : 255;
                    m_last = s; m_phase = 2; m_dwell = 0;
                end
            end else begin
                m_last = s;
                if (s == 0) m_phase = 1;
            end
        end
    endtask

    typedef struct {
        bit       v;
        bit [1:0] s;
        int       lk, er, ec, cy, ls;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // basic walk, a skip, error resync, freeze, hold, backward step, skip-by-2
        tbl[0]  = '{1, 2'd0, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 2'd1, 1, 0, 0, 0, 1};
        tbl[2]  = '{1, 2'd2, 1, 0, 0, 0, 2};
        tbl[3]  = '{1, 2'd3, 1, 0, 0, 0, 3};
        tbl[4]  = '{1, 2'd0, 1, 0, 0, 1, 0};
        tbl[5]  = '{1, 2'd1, 1, 0, 0, 1, 1};
        tbl[6]  = '{1, 2'd3, 0, 1, 1, 1, 3};
        tbl[7]  = '{1, 2'd2, 0, 1, 1, 1, 2};
        tbl[8]  = '{1, 2'd0, 1, 1, 1, 1, 0};
        tbl[9]  = '{0, 2'd1, 1, 1, 1, 1, 0};
        tbl[10] = '{1, 2'd1, 1, 1, 1, 1, 1};
        tbl[11] = '{1, 2'd1, 1, 1, 1, 1, 1};
        tbl[12] = '{1, 2'd0, 0, 1, 2, 1, 0};
        tbl[13] = '{1, 2'd0, 1, 1, 2, 1, 0};
        tbl[14] = '{1, 2'd2, 0, 1, 3, 1, 2};

        reset = 1'b0; in_valid = 1'b0; clr = 1'b0; in_state = 2'b00;
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
`ifdef STATE_MON_DWELL_EN
        chk("reset.dwell_timeout", int'(dwell_timeout), 0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, 1'b0, tbl[i].s);
            chk_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].er, tbl[i].ec, tbl[i].cy, tbl[i].ls);
        end

        // Saturation: now in error at 10; each pair = resync + skip violation
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 2'd0);
            drive(1'b1, 1'b0, 2'd2);
        end
        chk_all("sat", 0, 1, 255, 1, 2);

        // clr beats a same-cycle advance; last_state kept
        drive(1'b1, 1'b0, 2'd0);
        chk_all("pre_clr", 1, 1, 255, 1, 0);
        drive(1'b1, 1'b1, 2'd1);
        chk_all("clr", 0, 0, 0, 0, 0);
        drive(1'b1, 1'b0, 2'd3);          // acquire accepts any code
        chk_all("acq_any", 1, 0, 0, 0, 3);
        drive(1'b1, 1'b0, 2'd0);
        chk_all("acq_wrap", 1, 0, 0, 1, 0);

        // 15 more full wraps: 1 + 15 = 16 -> 0 modulo 2^4
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, 2'd1);
            drive(1'b1, 1'b0, 2'd2);
            drive(1'b1, 1'b0, 2'd3);
            drive(1'b1, 1'b0, 2'd0);
        end
        chk_all("cnt_wrap", 1, 0, 0, 0, 0);

        // Async reset between edges while tracking
        drive(1'b1, 1'b0, 2'd1);
        drive(1'b1, 1'b0, 2'd2);
        #3 reset = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        drive(1'b1, 1'b0, 2'd2);
        chk_all("post_rst", 1, 0, 0, 0, 2);

`ifdef STATE_MON_DWELL_EN
        pulse_reset();
        drive(1'b1, 1'b0, 2'd1);
        drive(1'b1, 1'b0, 2'd2);
        chk("dw.enter", int'(dwell_timeout), 0);
        drive(1'b1, 1'b0, 2'd2);
        chk("dw.h1", int'(dwell_timeout), 0);
        drive(1'b0, 1'b0, 2'd2);          // frozen, no count
        chk("dw.frz", int'(dwell_timeout), 0);
        drive(1'b1, 1'b0, 2'd2);
        chk("dw.h2", int'(dwell_timeout), 0);
        drive(1'b1, 1'b0, 2'd2);
        chk("dw.h3", int'(dwell_timeout), 1);
        drive(1'b1, 1'b0, 2'd2);
        chk("dw.h4", int'(dwell_timeout), 1);
        chk("dw.err", int'(err), 0);
        drive(1'b1, 1'b0, 2'd3);
        chk("dw.adv", int'(dwell_timeout), 0);
`endif

        // Randomized run against the reference model
        pulse_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            bit       v, c;
            bit [1:0] s;
            int       r;
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 59) == 0);
            r = $urandom_range(0, 9);
            if (r < 6)      s = 2'(m_last + 1);
            else if (r < 8) s = 2'(m_last);
            else            s = 2'($urandom_range(0, 3));
            drive(v, c, s);
            model_step(v, c, s);
            chk_all($sformatf("rnd%0d", i), (m_phase == 1) ? 1 : 0, int'(m_err), m_ec, m_cyc, m_last);
`ifdef STATE_MON_DWELL_EN
            chk($sformatf("rnd%0d.dwell_timeout", i), int'(dwell_timeout),
                (m_dwell >= DM) ? 1 : 0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
